spi_rx_fifo_mmio: RTL and testbench

// - Memory-mapped SPI receive peripheral for the picorv32 SoC. It replaces the bare SPI slave decode at 0x0001_xxxx.
// - Deserialises MOSI words of DATA_W bits and buffers them in a FIFO_DEPTH-entry RX FIFO.
// - Exposes data, status and control registers on the native picorv32 memory bus (mem_valid/mem_ready).
// - Adds configurable sampling edge, overrun detection and a registered one-wait-state bus response.

---
 rtl/spi_rx_fifo_mmio.sv | 278 +++++++++++++++++++++++++++
 tb/tb_spi_rx_fifo_mmio.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_rx_fifo_mmio.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo_mmio
// Memory-mapped SPI receive peripheral for the picorv32 native memory bus.
// MOSI words of DATA_W bits (MSB first) are deserialised in the clk_in domain
// and buffered in a FIFO_DEPTH-entry RX FIFO. The FIFO is read through
// RXDATA, and status/control are available through STATUS and CTRL.
//
// Register map (mem_addr[3:2]):
//   0 RXDATA (R)     head word, zero-extended; a read pops (0 when empty)
//   1 STATUS (R/W1C) [0] not_empty, [1] full, [2] overrun (W1C), [15:8] level
//   2 CTRL   (R/W)   [0] en, [1] edge (1: sample on sck fall), [15:8] thr
//   3 reserved       reads 0, writes ignored
//
// Ports:
//   clk_in     system clock
//   rst_in     asynchronous active-high reset
//   mem_valid  bus request, held until mem_ready
//   mem_ready  one-cycle response pulse, one cycle after accept
//   mem_addr   byte address, only [3:2] decoded
//   mem_wdata  write data
//   mem_wstrb  zero = read, nonzero = full-word write
//   mem_rdata  registered read data, valid while mem_ready=1
//   spi_sck    SPI clock (asynchronous, f_clk >= 4*f_sck)
//   spi_mosi   SPI data in
//   spi_cs     SPI chip select, active low
//   irq        level interrupt (only when SPI_RX_IRQ_EN is defined)
//
// Optional feature: define SPI_RX_IRQ_EN to add the irq port, the threshold
// field CTRL[15:8] and the registered interrupt logic. Without it CTRL[15:8]
// reads 0.
// -----------------------------------------------------------------------------
module spi_rx_fifo_mmio #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs
`ifdef SPI_RX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = LVL_W - 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  // Synchronisers and SPI sampling
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic                   sck_d_r;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   rise_s;
  logic                   fall_s;
  logic                   sample_s;
  logic [DATA_W-1:0]      shift_r;
  logic [DATA_W:0]        shift_ext_s;
  logic [DATA_W-1:0]      shift_nxt_s;
  logic [CNT_W-1:0]       bitcnt_r;
  logic                   push_s;

  // FIFO
  logic [DATA_W-1:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [LVL_W-1:0]       level_r;
  logic                   empty_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   push_ok_s;
  logic                   ovr_r;
  logic                   ovr_set_s;
  logic                   ovr_clr_s;

  // Bus / registers
  logic                   mem_ready_r;
  logic [31:0]            mem_rdata_r;
  logic [31:0]            rdata_nxt_s;
  logic                   accept_s;
  logic                   wr_s;
  logic [1:0]             sel_s;
  logic                   pop_req_s;
  logic                   ctrl_wr_s;
  logic                   en_r;
  logic                   edge_sel_r;
  logic [7:0]             thr_s;
  logic [7:0]             level8_s;
  logic [31:0]            head_ext_s;
  logic [31:0]            status_s;
  logic [31:0]            ctrl_s;
  logic                   unused_bits_s;

  assign unused_bits_s = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata};

  // Bring the SPI pins into clk_in; cs idles high so no frame starts on reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sck_sync_r  <= {SYNC_STAGES{1'b0}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cs_sync_r   <= {SYNC_STAGES{1'b1}};
      sck_d_r     <= 1'b0;
    end else begin
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], spi_sck};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs};
      sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_r[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s     = cs_sync_r[SYNC_STAGES-1];
  assign rise_s   = sck_s & ~sck_d_r;
  assign fall_s   = ~sck_s & sck_d_r;
  assign sample_s = (edge_sel_r ? fall_s : rise_s) & ~cs_s & en_r;

  // The extra bit lets DATA_W=1 shift without an empty part-select.
  assign shift_ext_s = {shift_r, mosi_s};
  assign shift_nxt_s = shift_ext_s[DATA_W-1:0];
  assign push_s      = sample_s & (bitcnt_r == LAST_BIT);

  // Deserialiser; cs high or en low discards any partial word.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      shift_r  <= {DATA_W{1'b0}};
      bitcnt_r <= {CNT_W{1'b0}};
    end else if (cs_s || !en_r) begin
      shift_r  <= {DATA_W{1'b0}};
      bitcnt_r <= {CNT_W{1'b0}};
    end else if (sample_s) begin
      shift_r  <= shift_nxt_s;
      bitcnt_r <= push_s ? {CNT_W{1'b0}} : bitcnt_r + CNT_W'(1);
    end
  end

  // Bus decode: a request is accepted only while no response is pending.
  assign accept_s  = mem_valid & ~mem_ready_r;
  assign wr_s      = |mem_wstrb;
  assign sel_s     = mem_addr[3:2];
  assign pop_req_s = accept_s & ~wr_s & (sel_s == 2'd0);
  assign ctrl_wr_s = accept_s & wr_s & (sel_s == 2'd2);
  assign ovr_clr_s = accept_s & wr_s & (sel_s == 2'd1) & mem_wdata[2];

  assign empty_s   = (level_r == {LVL_W{1'b0}});
  assign full_s    = (level_r == DEPTH_LVL);
  // A pop on an empty FIFO never happens, even if a push lands the same cycle.
  assign pop_s     = pop_req_s & ~empty_s;
  // When full, a concurrent pop frees the slot the push needs.
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign ovr_set_s = push_s & full_s & ~pop_s;

  // FIFO pointers and fill level.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      if (push_ok_s && !pop_s) begin
        level_r <= level_r + LVL_W'(1);
      end else if (pop_s && !push_ok_s) begin
        level_r <= level_r - LVL_W'(1);
      end
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_in) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= shift_nxt_s;
    end
  end

  // Sticky overrun flag; a new overrun beats a simultaneous W1C.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ovr_r <= 1'b0;
    end else if (ovr_set_s) begin
      ovr_r <= 1'b1;
    end else if (ovr_clr_s) begin
      ovr_r <= 1'b0;
    end
  end

  // CTRL enable and sampling-edge fields.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      en_r       <= 1'b1;
      edge_sel_r <= 1'b0;
    end else if (ctrl_wr_s) begin
      en_r       <= mem_wdata[0];
      edge_sel_r <= mem_wdata[1];
    end
  end

`ifdef SPI_RX_IRQ_EN
  logic [7:0] thr_r;
  logic       irq_r;

  // CTRL threshold field.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      thr_r <= 8'd1;
    end else if (ctrl_wr_s) begin
      thr_r <= mem_wdata[15:8];
    end
  end

  // Registered interrupt from the registered level and overrun flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= en_r && (((32'(level_r) >= 32'(thr_r)) && (thr_r != 8'd0)) || ovr_r);
    end
  end

  assign thr_s = thr_r;
  assign irq   = irq_r;
`else
  assign thr_s = 8'd0;
`endif

  assign level8_s   = 8'(level_r);
  assign head_ext_s = 32'(fifo_mem_r[rd_ptr_r]);
  assign status_s   = {16'h0000, level8_s, 5'b00000, ovr_r, full_s, ~empty_s};
  assign ctrl_s     = {16'h0000, thr_s, 6'b000000, edge_sel_r, en_r};

  // Read-data selection for the accepted request.
  always_comb begin
    rdata_nxt_s = 32'h0000_0000;
    case (sel_s)
      2'd0:    rdata_nxt_s = empty_s ? 32'h0000_0000 : head_ext_s;
      2'd1:    rdata_nxt_s = status_s;
      2'd2:    rdata_nxt_s = ctrl_s;
      default: rdata_nxt_s = 32'h0000_0000;
    endcase
  end

  // One-wait-state registered response.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      mem_ready_r <= 1'b1;
      mem_rdata_r <= wr_s ? 32'h0000_0000 : rdata_nxt_s;
    end else begin
      mem_ready_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_rdata = mem_rdata_r;

endmodule

// File: tb/tb_spi_rx_fifo_mmio.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_fifo_mmio
// Self-checking bench for spi_rx_fifo_mmio (default parameters). Directed
// scenarios plus a randomized phase, all checked against a queue-based model
// of the RX FIFO and overrun flag.
// -----------------------------------------------------------------------------
module tb_spi_rx_fifo_mmio;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        spi_sck;
  logic        spi_mosi;
  logic        spi_cs;
`ifdef SPI_RX_IRQ_EN
  logic        irq;
  localparam logic [31:0] CTRL_THR1 = 32'h0000_0100;
`else
  localparam logic [31:0] CTRL_THR1 = 32'h0000_0000;
`endif

  spi_rx_fifo_mmio dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs    (spi_cs)
`ifdef SPI_RX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 clk_in = ~clk_in;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: FIFO contents and sticky overrun.
  logic [7:0] ref_q[$];
  bit         ref_ovr  = 1'b0;
  bit         ref_edge = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_status();
    int lvl;
    lvl = ref_q.size();
    return {16'h0000, 8'(lvl), 5'b00000, ref_ovr, (lvl == 16), (lvl != 0)};
  endfunction

  function automatic void ref_push(input logic [7:0] w);
    if (ref_q.size() < 16) ref_q.push_back(w);
    else ref_ovr = 1'b1;
  endfunction

  // One bus transfer; checks one-cycle latency and the single-cycle ready pulse.
  task automatic bus_xfer(input logic [3:0] wstrb, input logic [1:0] idx, input logic [31:0] wdata,
                          input string tag, output logic [31:0] rdata);
    int lat;
    bit got;
    @(negedge clk_in);
    mem_valid = 1'b1;
    mem_addr  = 32'h0001_0000 | (32'(idx) << 2);
    mem_wstrb = wstrb;
    mem_wdata = wdata;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk_in);
      lat++;
      if (mem_ready) got = 1'b1;
    end
    rdata = mem_rdata;
    check_val({tag, "_lat"}, 32'(lat), 32'd1);
    @(negedge clk_in);
    check_val({tag, "_rdy_drop"}, {31'h0, mem_ready}, 32'h0);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic wr_reg(input logic [1:0] idx, input logic [31:0] d, input string tag);
    logic [31:0] dummy;
    bus_xfer(4'hF, idx, d, tag, dummy);
  endtask

  task automatic rd_reg(input logic [1:0] idx, input string tag, output logic [31:0] d);
    bus_xfer(4'h0, idx, 32'h0, tag, d);
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = 32'h0;
    if (ref_q.size() > 0) e = {24'h0, ref_q.pop_front()};
    rd_reg(2'd0, tag, d);
    check_val(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    rd_reg(2'd1, tag, d);
    check_val(tag, d, exp_status());
  endtask

  // Send the top nbits of w MSB first inside one cs-low frame.
  task automatic spi_frame(input logic [7:0] w, input int nbits, input bit fall_mode);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk_in);
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!fall_mode) begin
        spi_mosi = w[i];
        repeat (4) @(negedge clk_in);
        spi_sck = 1'b1;
        repeat (4) @(negedge clk_in);
        spi_sck = 1'b0;
      end else begin
        spi_sck  = 1'b1;
        spi_mosi = w[i];
        repeat (4) @(negedge clk_in);
        spi_sck = 1'b0;
        repeat (4) @(negedge clk_in);
      end
    end
    repeat (4) @(negedge clk_in);
    spi_cs = 1'b1;
    repeat (6) @(negedge clk_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  w;
    int          r;
    bit          m;
    rst_in    = 1'b1;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    spi_sck   = 1'b0;
    spi_mosi  = 1'b0;
    spi_cs    = 1'b1;
    repeat (3) @(negedge clk_in);
    check_val("rst_ready_in_reset", {31'h0, mem_ready}, 32'h0);
    rst_in = 1'b0;
    @(negedge clk_in);
    check_val("rst_ready", {31'h0, mem_ready}, 32'h0);
    rd_reg(2'd1, "rst_status", d);
    check_val("rst_status", d, 32'h0000_0000);
    rd_reg(2'd2, "rst_ctrl", d);
    check_val("rst_ctrl", d, CTRL_THR1 | 32'h1);

    // Single word
    spi_frame(8'hA5, 8, 1'b0);
    ref_push(8'hA5);
    rd_reg(2'd1, "a5_status", d);
    check_val("a5_status", d, 32'h0000_0101);
    read_rx("a5_data");
    read_status("a5_status_after");

    // Aborted frame then a full one
    spi_frame(8'hFF, 5, 1'b0);
    spi_frame(8'h3C, 8, 1'b0);
    ref_push(8'h3C);
    read_status("abort_status");
    read_rx("abort_data");

    // Overrun: 17 words into a 16-deep FIFO
    for (int i = 0; i <= 16; i++) begin
      spi_frame(8'(i), 8, 1'b0);
      ref_push(8'(i));
    end
    rd_reg(2'd1, "ovr_status", d);
    check_val("ovr_status", d, 32'h0000_1007);
    for (int i = 0; i < 16; i++) read_rx("ovr_data");
    read_status("ovr_drained");
    wr_reg(2'd1, 32'h0000_0004, "ovr_w1c");
    ref_ovr = 1'b0;
    read_status("ovr_cleared");
    read_rx("empty_read");

    // Ignored writes and reserved register
    spi_frame(8'h5A, 8, 1'b0);
    ref_push(8'h5A);
    wr_reg(2'd0, 32'h0000_00FF, "wr_rxdata");
    wr_reg(2'd3, 32'hFFFF_FFFF, "wr_rsvd");
    wr_reg(2'd1, 32'hFFFF_FFFB, "wr_status_ro");
    read_status("ro_status");
    rd_reg(2'd3, "rsvd", d);
    check_val("rsvd", d, 32'h0);

    // Falling-edge sampling
    wr_reg(2'd2, 32'h0000_0103, "ctrl_edge");
    rd_reg(2'd2, "ctrl_edge_rd", d);
    check_val("ctrl_edge_rd", d, CTRL_THR1 | 32'h3);
    spi_frame(8'h81, 8, 1'b1);
    ref_push(8'h81);
    read_rx("edge_old");
    read_rx("edge_81");

    // Disabled receiver ignores traffic
    wr_reg(2'd2, 32'h0000_0100, "ctrl_dis");
    spi_frame(8'hEE, 8, 1'b0);
    read_status("dis_status");
    wr_reg(2'd2, 32'h0000_0101, "ctrl_en");

`ifdef SPI_RX_IRQ_EN
    wr_reg(2'd2, 32'h0000_0301, "ctrl_thr3");
    spi_frame(8'h11, 8, 1'b0);
    ref_push(8'h11);
    spi_frame(8'h22, 8, 1'b0);
    ref_push(8'h22);
    check_val("irq_two", {31'h0, irq}, 32'h0);
    spi_frame(8'h33, 8, 1'b0);
    ref_push(8'h33);
    check_val("irq_three", {31'h0, irq}, 32'h1);
    read_rx("irq_pop");
    check_val("irq_after_pop", {31'h0, irq}, 32'h0);
    read_rx("irq_drain1");
    read_rx("irq_drain2");
    wr_reg(2'd2, 32'h0000_0101, "ctrl_thr1");
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 60; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        w = 8'($urandom);
        m = 1'($urandom);
        if (m != ref_edge) begin
          wr_reg(2'd2, 32'h0000_0101 | (32'(m) << 1), "rnd_ctrl");
          ref_edge = m;
        end
        spi_frame(w, 8, m);
        ref_push(w);
      end else if (r == 4) begin
        spi_frame(8'($urandom), $urandom_range(1, 7), ref_edge);
      end else if (r <= 7) begin
        read_rx("rnd_data");
      end else if (r == 8) begin
        read_status("rnd_status");
      end else begin
        d = $urandom;
        bus_xfer(4'($urandom_range(1, 15)), 2'd1, d, "rnd_w1c", w);
        if (d[2]) ref_ovr = 1'b0;
        read_status("rnd_w1c_status");
      end
    end

    // Asynchronous reset in the middle of a frame
    spi_frame(8'h77, 8, ref_edge);
    ref_push(8'h77);
    spi_cs = 1'b0;
    repeat (4) @(negedge clk_in);
    spi_sck = 1'b1;
    #2;
    rst_in = 1'b1;
    #1;
    check_val("midrst_ready", {31'h0, mem_ready}, 32'h0);
    spi_sck = 1'b0;
    spi_cs  = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    ref_q.delete();
    ref_ovr = 1'b0;
    repeat (4) @(negedge clk_in);
    read_status("midrst_status");
    rd_reg(2'd2, "midrst_ctrl", d);
    check_val("midrst_ctrl", d, CTRL_THR1 | 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
